// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
//   Bundles the scan controller's control inputs and display outputs.
//   Clock and reset stay as plain ports on the controller.
//
// Signals
//   enable      1 = scan runs, 0 = display dark and scan parked
//   digits_in   4*nO bits of BCD/hex nibbles, digit k = digits_in[4k+3:4k]
//   sel         registered digit index driving the anode demux select
//   en          registered demux data input (1 = digit lit)
//   digit       registered nibble of the snapshot digit at sel
//   frame_done  one-cycle pulse on the last cycle of the final digit's slot
//
// Modports
//   master  drives enable/digits_in and observes the display outputs
//   slave   the scan controller itself

interface display_scan_ctrl_if #(
    parameter int nO = 4,
    parameter int nS = 2
);
    logic            enable;
    logic [4*nO-1:0] digits_in;
    logic [nS-1:0]   sel;
    logic            en;
    logic [3:0]      digit;
    logic            frame_done;

    modport master (
        output enable, digits_in,
        input  sel, en, digit, frame_done
    );

    modport slave (
        input  enable, digits_in,
        output sel, en, digit, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for an nO-digit seven-segment display.
//   Each digit owns a DIV-cycle slot whose first BLANK cycles are dark to
//   suppress ghosting. The display value is snapshotted when the scan starts
//   and at every frame wrap, so a frame never mixes old and new digits.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous reset, active low
//   bus    display_scan_ctrl_if.slave (enable, digits_in in; sel, en, digit,
//          frame_done out; all outputs registered)
//
// Configuration
//   LEADING_ZERO_BLANK_EN  when defined, digit k>0 stays dark for its whole
//                          slot if snapshot digits k..nO-1 are all zero.
//                          Slot timing, sel and frame_done are unaffected.

module display_scan_ctrl #(
    parameter int nO    = 4,
    parameter int nS    = 2,
    parameter int DIV   = 50000,
    parameter int BLANK = 5000,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [nS-1:0] SEL_LAST   = nS'(nO - 1);

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [nS-1:0]          sel_q, sel_nxt;
    logic                   en_q, en_nxt;
    logic [3:0]             digit_q, digit_nxt;
    logic                   done_q, done_nxt;
    logic [nO-1:0][3:0]     snapshot, snap_nxt;
    logic                   visible;
`ifdef LEADING_ZERO_BLANK_EN
    logic                   upper_nz;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            digit_q  <= 4'h0;
            done_q   <= 1'b0;
            snapshot <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel_q    <= sel_nxt;
            en_q     <= en_nxt;
            digit_q  <= digit_nxt;
            done_q   <= done_nxt;
            snapshot <= snap_nxt;
        end
    end

    // All outputs are derived from the next-state values, so en, sel and
    // digit always move together on one edge and the demux never lights
    // a digit with a stale index.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        snap_nxt  = snapshot;

        if (!bus.enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            sel_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    snap_nxt  = bus.digits_in;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                    state_nxt = (BLANK == 0) ? S_ON : S_BLANK;
                end
                S_BLANK: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == BLANK_LAST) begin
                        state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (cnt == DIV_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = (BLANK == 0) ? S_ON : S_BLANK;
                        // Frame wrap: the only point where a new value is taken.
                        if (sel_q == SEL_LAST) begin
                            sel_nxt  = '0;
                            snap_nxt = bus.digits_in;
                        end else begin
                            sel_nxt = sel_q + nS'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    sel_nxt   = '0;
                end
            endcase
        end

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every more-significant digit
        // are zero; digit 0 is always shown.
        upper_nz = 1'b0;
        for (int k = 0; k < nO; k++) begin
            if (k >= int'(sel_nxt) && snap_nxt[k] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        visible = (sel_nxt == '0) || upper_nz;
`else
        visible = 1'b1;
`endif

        en_nxt    = (state_nxt == S_ON) && visible;
        // Registered pulse that lands on the last cycle of the final slot.
        done_nxt  = (state_nxt != S_IDLE) && (cnt_nxt == DIV_LAST) && (sel_nxt == SEL_LAST);
        digit_nxt = snap_nxt[sel_nxt];
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.digit      = digit_q;
    assign bus.frame_done = done_q;

endmodule
